// File: rtl/cfg_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// cfg_dispatch_pkg
//   Shared types and helpers for the configuration-write dispatcher.
//   - ch_state_e : per-channel handshake state (idle / config pending)
//   - ADDR_RSVD  : address that never selects a channel
//   - ch_idx()   : maps a write address onto its channel index
// -----------------------------------------------------------------------------
package cfg_dispatch_pkg;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,  // no undelivered configuration
    CH_PEND = 1'b1   // configuration presented, waiting for the consumer
  } ch_state_e;

  localparam int ADDR_RSVD = 0;

  // Channel i answers to address i+1; address 0 is kept free so that an
  // all-zero bus never disturbs a target.
  function automatic int ch_idx(input int addr);
    return addr - 1;
  endfunction

endpackage

// File: rtl/cfg_dispatch_ch.sv
// -----------------------------------------------------------------------------
// cfg_dispatch_ch
//   One dispatcher channel: shadow register plus valid/ready handshake FSM.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     wr_i         accepted write addressed to this channel (one-cycle strobe)
//     wr_data_i    data of that write
//     ch_ready_i   consumer acknowledge (ignored in pulse mode)
//     ch_valid_o   registered "new config" level or one-cycle pulse
//     ch_data_o    shadow register
// -----------------------------------------------------------------------------
module cfg_dispatch_ch
  import cfg_dispatch_pkg::*;
#(
  parameter int                 DATA_W     = 16,
  parameter int                 PULSE_MODE = 0,
  parameter logic [DATA_W-1:0]  RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ch_ready_i,
  output logic              ch_valid_o,
  output logic [DATA_W-1:0] ch_data_o
);

  ch_state_e         state_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow register is ordinary flops, not a memory, so it is
      // reset like any other state; consumers see RST_VAL straight out of reset.
      state_q <= CH_IDLE;
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      // The top only raises wr_i when this channel is not stalled, so the
      // data stays stable while valid is high and ready is low.
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (wr_i) data_q <= wr_data_i;

      if (PULSE_MODE != 0) begin
        valid_q <= wr_i;
        state_q <= wr_i ? CH_PEND : CH_IDLE;
      end else begin
        case (state_q)
          CH_IDLE: begin
            if (wr_i) begin
              state_q <= CH_PEND;
              valid_q <= 1'b1;
            end
          end
          CH_PEND: begin
            // A new write here implies ch_ready_i was high: the old config is
            // consumed and the new one presented without a bubble.
            if (wr_i) begin
              state_q <= CH_PEND;
              valid_q <= 1'b1;
            end else if (ch_ready_i) begin
              state_q <= CH_IDLE;
              valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= CH_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_valid_o = valid_q;
  assign ch_data_o  = data_q;

endmodule

// File: rtl/cfg_dispatch.sv
// -----------------------------------------------------------------------------
// cfg_dispatch
//   Decodes {address,data} host writes into NUM_CH shadow registers, each with
//   its own valid/ready handshake, and counts writes to unmapped addresses.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     in_valid    host write request
//     in_ready    write can be accepted this cycle (combinational)
//     in_addr     write address, channel = in_addr-1, address 0 never hits
//     in_data     write data
//     ch_valid    per-channel new-config strobe (pulse) or level
//     ch_ready    per-channel consume acknowledge
//     ch_data     flattened shadow registers, channel 0 at the LSBs
//     err_cnt     saturating count of accepted unmapped writes
//     err_clr     synchronous clear of err_cnt, wins over an increment
// -----------------------------------------------------------------------------
module cfg_dispatch
  import cfg_dispatch_pkg::*;
#(
  parameter int                         NUM_CH     = 3,
  parameter int                         ADDR_W     = 2,
  parameter int                         DATA_W     = 16,
  parameter int                         PULSE_MODE = 0,
  parameter logic [NUM_CH*DATA_W-1:0]   RST_VALS   = 'h1,
  parameter int                         ERR_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [ERR_W-1:0]           err_cnt,
  input  logic                       err_clr
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] ch_wr;
  logic              unmapped;
  logic              accept;
  logic [ERR_W-1:0]  err_q, err_d;

  // Address decode: at most one bit set, none for address 0 or beyond NUM_CH.
  always_comb begin
    // NOTE: every bit gets a default before the loop so no latch is inferred.
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = (int'(in_addr) != ADDR_RSVD) && (ch_idx(int'(in_addr)) == i);
    end
  end

  assign unmapped = ~|hit;

  // Only the addressed channel can block the host; other channels keep
  // accepting writes while one consumer is stalled.
  assign stall    = hit & ch_valid & ~ch_ready;
  assign in_ready = (PULSE_MODE != 0) ? 1'b1 : ~|stall;
  assign accept   = in_valid & in_ready;
  assign ch_wr    = hit & {NUM_CH{accept}};

  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (accept && unmapped && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cfg_dispatch_ch #(
      .DATA_W     (DATA_W),
      .PULSE_MODE (PULSE_MODE),
      .RST_VAL    (RST_VALS[g*DATA_W +: DATA_W])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (ch_wr[g]),
      .wr_data_i  (in_data),
      .ch_ready_i (ch_ready[g]),
      .ch_valid_o (ch_valid[g]),
      .ch_data_o  (ch_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_cfg_dispatch.sv
// -----------------------------------------------------------------------------
// tb_cfg_dispatch
//   Two dispatchers driven by the same host/consumer stimulus: u_lvl (held
//   valid/ready, 2-bit error counter) and u_pls (pulse mode, 8-bit counter).
//   The driver keeps a transaction-level model (outstanding-config flags and
//   an error count), predicts in_ready, and queues every config a channel
//   must present next. A separate monitor pops those queues whenever a DUT
//   presents a new config and compares data, stability and error count.
// -----------------------------------------------------------------------------
module tb_cfg_dispatch;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam logic [NCH*DW-1:0] RST_IMG = 48'h00C3_00B2_0001;
  localparam int ERR_MAX [2] = '{3, 255};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic [1:0]      in_addr  = '0;
  logic [DW-1:0]   in_data  = '0;
  logic [NCH-1:0]  ch_ready = '0;
  logic            err_clr  = 1'b0;

  logic            rdy0, rdy1;
  logic [NCH-1:0]  v0, v1;
  logic [NCH*DW-1:0] d0, d1;
  logic [1:0]      e0;
  logic [7:0]      e1;

  cfg_dispatch #(
    .NUM_CH(NCH), .ADDR_W(2), .DATA_W(DW), .PULSE_MODE(0),
    .RST_VALS(RST_IMG), .ERR_W(2)
  ) u_lvl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_addr(in_addr), .in_data(in_data), .ch_valid(v0), .ch_ready(ch_ready),
    .ch_data(d0), .err_cnt(e0), .err_clr(err_clr)
  );

  cfg_dispatch #(
    .NUM_CH(NCH), .ADDR_W(2), .DATA_W(DW), .PULSE_MODE(1),
    .RST_VALS(RST_IMG), .ERR_W(8)
  ) u_pls (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_addr(in_addr), .in_data(in_data), .ch_valid(v1), .ch_ready(ch_ready),
    .ch_data(d1), .err_cnt(e1), .err_clr(err_clr)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Scoreboard: configs each channel must present, and expected err_cnt per edge.
  logic [DW-1:0] exp_q [2][NCH][$];
  int            err_q [2][$];

  // Reference model state.
  bit pend [NCH];     // level-mode channel holds an unconsumed config
  int err_m [2];

  // Monitor snapshot taken just before each active edge.
  logic [NCH-1:0]    hs_s [2];
  logic [NCH-1:0]    pv_s [2];
  logic [NCH*DW-1:0] pd_s [2];

  function automatic logic f_rdy(int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic [NCH-1:0] f_valid(int d);
    return (d == 0) ? v0 : v1;
  endfunction
  function automatic logic [NCH*DW-1:0] f_data(int d);
    return (d == 0) ? d0 : d1;
  endfunction
  function automatic logic [7:0] f_err(int d);
    return (d == 0) ? {6'b0, e0} : e1;
  endfunction

  task automatic check(string name, int d, logic [NCH*DW-1:0] got, logic [NCH*DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h want %0h", name, d, $time, got, want);
    end
  endtask

  // One host/consumer cycle: drive, predict in_ready, update the model.
  task automatic apply(bit v, logic [1:0] a, logic [DW-1:0] dat, logic [NCH-1:0] rdy, bit clr);
    bit hit, busy, exp_rdy, acc;
    int idx;
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = dat; ch_ready = rdy; err_clr = clr;
    #1;
    hit = (a != 2'd0);
    idx = int'(a) - 1;
    for (int d = 0; d < 2; d++) begin
      busy    = hit ? (pend[idx] && !rdy[idx]) : 1'b0;
      exp_rdy = (d == 1) ? 1'b1 : !busy;
      check("in_ready", d, NCH*DW'(f_rdy(d)), NCH*DW'(exp_rdy));
      acc = v && exp_rdy;
      if (acc && hit) exp_q[d][idx].push_back(dat);
      if (d == 0) begin
        for (int i = 0; i < NCH; i++)
          pend[i] = (pend[i] && !rdy[i]) || (acc && hit && idx == i);
      end
      if (clr) err_m[d] = 0;
      else if (acc && !hit && err_m[d] < ERR_MAX[d]) err_m[d]++;
      err_q[d].push_back(err_m[d]);
    end
  endtask

  // Asynchronous reset asserted in the middle of the high clock phase.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", d, NCH*DW'(f_valid(d)), '0);
      check("rst_data", d, f_data(d), RST_IMG);
      check("rst_err", d, NCH*DW'(f_err(d)), '0);
      check("rst_in_ready", d, NCH*DW'(f_rdy(d)), NCH*DW'(1));
      err_m[d] = 0;
      err_q[d].delete();
      for (int i = 0; i < NCH; i++) exp_q[d][i].delete();
    end
    for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Snapshot of handshake state seen by the upcoming edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        hs_s[d] = f_valid(d) & ch_ready;
        pv_s[d] = f_valid(d);
        pd_s[d] = f_data(d);
      end
    end
  end

  // Monitor: compare what each DUT presents after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          logic [NCH-1:0]    vv;
          logic [NCH*DW-1:0] dd;
          vv = f_valid(d);
          dd = f_data(d);
          for (int i = 0; i < NCH; i++) begin
            logic    new_pres;
            logic [DW-1:0] cur, prev;
            cur  = dd[i*DW +: DW];
            prev = pd_s[d][i*DW +: DW];
            new_pres = (d == 1) ? vv[i] : (vv[i] && (!pv_s[d][i] || hs_s[d][i]));
            if (new_pres) begin
              if (exp_q[d][i].size() == 0) check("spurious_valid", d, NCH*DW'(vv[i]), '0);
              else check("ch_data", d, NCH*DW'(cur), NCH*DW'(exp_q[d][i].pop_front()));
            end else begin
              check("data_stable", d, NCH*DW'(cur), NCH*DW'(prev));
            end
            if (d == 0 && pv_s[d][i] && !hs_s[d][i])
              check("valid_hold", d, NCH*DW'(vv[i]), NCH*DW'(1));
            check("missed_valid", d, NCH*DW'(exp_q[d][i].size()), '0);
          end
          if (err_q[d].size() > 0)
            check("err_cnt", d, NCH*DW'(f_err(d)), NCH*DW'(err_q[d].pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) apply(0, 2'd0, '0, 3'b111, 0);

    do_reset();

    // Single write, consumer ready: one-cycle presentation on both DUTs.
    apply(1, 2'd1, 16'h1A2B, 3'b111, 0);
    repeat (2) apply(0, 2'd0, '0, 3'b111, 0);

    // Stall on channel 1, cross-channel write, then release.
    apply(1, 2'd2, 16'h0011, 3'b101, 0);
    apply(1, 2'd2, 16'h0022, 3'b101, 0);
    apply(1, 2'd3, 16'hBEEF, 3'b101, 0);
    apply(0, 2'd0, '0, 3'b101, 0);
    apply(1, 2'd2, 16'h0022, 3'b111, 0);
    repeat (2) apply(0, 2'd0, '0, 3'b111, 0);

    // Unmapped writes: saturation of the 2-bit counter, clear, clear-vs-increment.
    repeat (5) apply(1, 2'd0, 16'hDEAD, 3'b111, 0);
    apply(0, 2'd0, '0, 3'b111, 1);
    apply(1, 2'd0, '0, 3'b111, 0);
    apply(1, 2'd0, '0, 3'b111, 1);
    apply(0, 2'd0, '0, 3'b111, 0);

    // Back-to-back writes, consumers not ready: two pulses on the pulse DUT.
    apply(1, 2'd1, 16'h0001, 3'b000, 0);
    apply(1, 2'd1, 16'h0002, 3'b000, 0);
    repeat (2) apply(0, 2'd0, '0, 3'b000, 0);

    // Reset while configs are still pending.
    apply(1, 2'd2, 16'h5555, 3'b000, 0);
    apply(0, 2'd0, '0, 3'b000, 0);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [NCH-1:0] r;
      r = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
      apply(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
            r, ($urandom_range(0, 31) == 0));
    end

    repeat (4) apply(0, 2'd0, '0, 3'b111, 0);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
